alu_issue: RTL and testbench

- Sequencer that drives the Game Boy ALU.
- Accepts one decoded 8-bit opcode per transaction: unprefixed ALU group, ALU-immediate, A-only ops, or CB-prefixed.
- Fetches the operand from the register file or from memory at (HL), and issues alu_op, operands and bit index.
- Writes back the result and the flags.
- Sits between the CPU decode stage and the ALU, register file and memory bus.

---
 rtl/alu_issue.sv | 242 ++++++++++++++++++++++++
 tb/tb_alu_issue.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - Game Boy ALU issue sequencer.
// Decodes one opcode, gathers the operand from the register file, immediate or (HL), and writes the result back.
module alu_issue #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_cb,
    input  logic [7:0] in_opcode,
    input  logic [7:0] in_imm,
    output logic [2:0] rf_rd_sel,
    input  logic [7:0] rf_rd_data,
    input  logic [7:0] rf_a_data,
    output logic       rf_wr_en,
    output logic [2:0] rf_wr_sel,
    output logic [7:0] rf_wr_data,
    input  logic [3:0] f_in,
    output logic       f_wr_en,
    output logic [3:0] f_out,
    output logic       mem_req,
    output logic       mem_we,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack,
    output logic [4:0] alu_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_bit_index,
    output logic [3:0] alu_flags_in,
    input  logic [7:0] alu_result,
    input  logic [3:0] alu_flags_out,
    output logic       done,
    output logic       err
);

    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [4:0] OP_NONE = 5'b11000;

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB_MEM} state_t;

    typedef struct packed {
        logic       def;
        logic [4:0] op;
        logic       cb;
        logic       a_only;
        logic       use_imm;
        logic       use_mem;
        logic       wr_data;
        logic       wr_flags;
        logic       swap;
        logic       zforce;
        logic       mem_dest;
    } dec_t;

    function automatic dec_t decode(input logic cb, input logic [7:0] opc);
        dec_t d;
        d    = '0;
        d.op = OP_NONE;
        d.cb = cb;
        if (cb) begin
            d.def = 1'b1;
            case (opc[7:6])
                2'b00:   d.op = {2'b01, opc[5:3]};
                2'b01:   d.op = 5'b11101;
                2'b10:   d.op = 5'b11110;
                default: d.op = 5'b11111;
            endcase
            d.use_mem  = (opc[2:0] == 3'd6);
            d.wr_data  = (opc[7:6] != 2'b01);
            d.wr_flags = ~opc[7];
            d.swap     = (opc[7:3] == 5'b00110);
            d.mem_dest = d.use_mem & d.wr_data;
        end else if (opc[7:6] == 2'b10) begin
            d.def      = 1'b1;
            d.op       = {2'b00, opc[5:3]};
            d.use_mem  = (opc[2:0] == 3'd6);
            d.wr_data  = (opc[5:3] != 3'b111);
            d.wr_flags = 1'b1;
        end else if (opc[7:6] == 2'b11 && opc[2:0] == 3'b110) begin
            d.def      = 1'b1;
            d.op       = {2'b00, opc[5:3]};
            d.use_imm  = 1'b1;
            d.wr_data  = (opc[5:3] != 3'b111);
            d.wr_flags = 1'b1;
        end else if (opc[7:6] == 2'b00 && opc[2:0] == 3'b111) begin
            d.def      = 1'b1;
            d.a_only   = 1'b1;
            d.wr_data  = 1'b1;
            d.wr_flags = 1'b1;
            if (opc[5]) begin
                d.op = {3'b101, opc[4:3]};
            end else begin
                // Accumulator rotates always clear Z, unlike their CB forms.
                d.op     = {2'b01, opc[5:3]};
                d.zforce = 1'b1;
            end
        end
        return d;
    endfunction

    function automatic logic needs_fetch(input logic cb, input logic [7:0] opc);
        dec_t d;
        d = decode(cb, opc);
        return d.def & d.use_mem;
    endfunction

    state_t        state_q, state_d;
    logic [7:0]    op_q, op_d;
    logic          cb_q, cb_d;
    logic [7:0]    imm_q, imm_d;
    logic [7:0]    opnd_q, opnd_d;
    logic [7:0]    res_q, res_d;
    logic [CW-1:0] cnt_q, cnt_d;

    dec_t       dq;
    logic [2:0] src;
    logic       exec, mem_busy, timeout_hit;
    logic [7:0] opv;

    assign dq          = decode(cb_q, op_q);
    assign src         = op_q[2:0];
    assign exec        = (state_q == EXEC);
    assign mem_busy    = (state_q == FETCH) || (state_q == WB_MEM);
    assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == CW'(MEM_TIMEOUT));
    assign opv         = dq.use_mem ? opnd_q : (dq.use_imm ? imm_q : rf_rd_data);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cb_d    = cb_q;
        imm_d   = imm_q;
        opnd_d  = opnd_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = in_opcode;
                    cb_d    = in_cb;
                    imm_d   = in_imm;
                    opnd_d  = '0;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = needs_fetch(in_cb, in_opcode) ? FETCH : EXEC;
                end
            end
            FETCH: begin
                if (timeout_hit) begin
                    state_d = IDLE;
                end else if (mem_ack) begin
                    opnd_d  = mem_rdata;
                    state_d = EXEC;
                end else if (MEM_TIMEOUT != 0) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            EXEC: begin
                if (dq.def && dq.mem_dest) begin
                    res_d   = alu_result;
                    cnt_d   = '0;
                    state_d = WB_MEM;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                if (timeout_hit || mem_ack) begin
                    state_d = IDLE;
                end else if (MEM_TIMEOUT != 0) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            cb_q    <= 1'b0;
            imm_q   <= '0;
            opnd_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cb_q    <= cb_d;
            imm_q   <= imm_d;
            opnd_q  <= opnd_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        in_ready      = (state_q == IDLE);
        alu_flags_in  = f_in;
        alu_op        = OP_NONE;
        alu_a         = '0;
        alu_b         = '0;
        alu_bit_index = '0;
        rf_rd_sel     = '0;
        rf_wr_en      = 1'b0;
        rf_wr_sel     = '0;
        rf_wr_data    = '0;
        f_wr_en       = 1'b0;
        f_out         = '0;
        if (exec && dq.def) begin
            alu_op        = dq.op;
            rf_rd_sel     = dq.a_only ? 3'd7 : src;
            alu_a         = dq.cb ? opv : rf_a_data;
            alu_b         = dq.a_only ? rf_a_data : opv;
            alu_bit_index = dq.cb ? op_q[5:3] : 3'd0;
            if (dq.wr_data && !dq.mem_dest) begin
                rf_wr_en   = 1'b1;
                rf_wr_sel  = dq.cb ? src : 3'd7;
                rf_wr_data = alu_result;
            end
            if (dq.wr_flags) begin
                f_wr_en = 1'b1;
                if (dq.swap)
                    f_out = {(alu_result == 8'd0), alu_flags_out[2:0]};
                else if (dq.zforce)
                    f_out = {1'b0, alu_flags_out[2:0]};
                else
                    f_out = alu_flags_out;
            end
        end
        mem_req   = mem_busy && !timeout_hit;
        mem_we    = (state_q == WB_MEM) && !timeout_hit;
        mem_wdata = mem_we ? res_q : 8'd0;
        // A timed-out access ends the transaction without any data write.
        done = (exec && (!dq.def || !dq.mem_dest))
            || (mem_busy && timeout_hit)
            || ((state_q == WB_MEM) && !timeout_hit && mem_ack);
        err  = (exec && !dq.def) || (mem_busy && timeout_hit);
    end

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - directed testbench for alu_issue.
// Drives the register file, memory and ALU responses by hand and checks every strobe.
module tb_alu_issue;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_cb = 1'b0;
    logic [7:0] in_opcode = 8'h00;
    logic [7:0] in_imm = 8'h00;
    logic [2:0] rf_rd_sel;
    logic [7:0] rf_rd_data;
    logic [7:0] rf_a_data;
    logic       rf_wr_en;
    logic [2:0] rf_wr_sel;
    logic [7:0] rf_wr_data;
    logic [3:0] f_in = 4'b0000;
    logic       f_wr_en;
    logic [3:0] f_out;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic       mem_ack = 1'b0;
    logic [4:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_bit_index;
    logic [3:0] alu_flags_in;
    logic [7:0] alu_result = 8'h00;
    logic [3:0] alu_flags_out = 4'b0000;
    logic       done;
    logic       err;

    logic [7:0] regs [8];
    int passed = 0;
    int total  = 0;

    assign rf_rd_data = regs[rf_rd_sel];
    assign rf_a_data  = regs[7];

    always #5 clk = ~clk;

    alu_issue #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_cb(in_cb),
        .in_opcode(in_opcode), .in_imm(in_imm),
        .rf_rd_sel(rf_rd_sel), .rf_rd_data(rf_rd_data), .rf_a_data(rf_a_data),
        .rf_wr_en(rf_wr_en), .rf_wr_sel(rf_wr_sel), .rf_wr_data(rf_wr_data),
        .f_in(f_in), .f_wr_en(f_wr_en), .f_out(f_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_bit_index(alu_bit_index), .alu_flags_in(alu_flags_in),
        .alu_result(alu_result), .alu_flags_out(alu_flags_out),
        .done(done), .err(err)
    );

    task automatic offer(input logic cb, input logic [7:0] op, input logic [7:0] imm);
        in_cb = cb; in_opcode = op; in_imm = imm; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; #1; rst = 1'b1; #1;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready); else passed++;
        total++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got=%b want=0", mem_req); else passed++;
        total++; if (alu_op !== 5'b11000) $display("FAIL reset_alu_op got=%b want=11000", alu_op); else passed++;
        total++; if ({done, err, rf_wr_en, f_wr_en} !== 4'b0000) $display("FAIL reset_strobes got=%b want=0000", {done, err, rf_wr_en, f_wr_en}); else passed++;
        @(posedge clk); @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic test_add();
        regs[7] = 8'h3A; regs[0] = 8'hC6; alu_result = 8'h00; alu_flags_out = 4'b1011;
        offer(1'b0, 8'h80, 8'h00);
        total++; if (alu_op !== 5'b00000) $display("FAIL add_alu_op got=%b want=00000", alu_op); else passed++;
        total++; if ({alu_a, alu_b} !== 16'h3AC6) $display("FAIL add_operands got=%h want=3ac6", {alu_a, alu_b}); else passed++;
        total++; if ({rf_wr_en, rf_wr_sel, rf_wr_data} !== {1'b1, 3'd7, 8'h00}) $display("FAIL add_rf_write got=%b/%0d/%h want=1/7/00", rf_wr_en, rf_wr_sel, rf_wr_data); else passed++;
        total++; if ({f_wr_en, f_out} !== 5'b11011) $display("FAIL add_flags got=%b want=11011", {f_wr_en, f_out}); else passed++;
        total++; if ({done, err} !== 2'b10) $display("FAIL add_done got=%b want=10", {done, err}); else passed++;
        @(posedge clk); #1;
        total++; if ({in_ready, done} !== 2'b10) $display("FAIL add_return_idle got=%b want=10", {in_ready, done}); else passed++;
    endtask

    task automatic test_imm();
        regs[7] = 8'h10; alu_result = 8'h15; alu_flags_out = 4'b0000;
        offer(1'b0, 8'hC6, 8'h05);
        total++; if ({alu_a, alu_b, rf_wr_data} !== 24'h100515) $display("FAIL imm_path got=%h want=100515", {alu_a, alu_b, rf_wr_data}); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_cp_hl();
        int reqs = 0;
        regs[7] = 8'h10; alu_result = 8'hF0; alu_flags_out = 4'b0101;
        offer(1'b0, 8'hBE, 8'h00);
        for (int i = 0; i < 3; i++) begin
            if (mem_req === 1'b1 && mem_we === 1'b0 && done === 1'b0) reqs++;
            if (i == 2) begin mem_ack = 1'b1; mem_rdata = 8'h20; end
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end
        total++; if (reqs !== 3) $display("FAIL cp_fetch_cycles got=%0d want=3", reqs); else passed++;
        total++; if ({alu_op, alu_a, alu_b} !== {5'b00111, 8'h10, 8'h20}) $display("FAIL cp_alu got=%b/%h/%h want=00111/10/20", alu_op, alu_a, alu_b); else passed++;
        total++; if ({rf_wr_en, f_wr_en, f_out} !== 6'b010101) $display("FAIL cp_writeback got=%b want=010101", {rf_wr_en, f_wr_en, f_out}); else passed++;
        total++; if ({done, mem_req} !== 2'b10) $display("FAIL cp_done got=%b want=10", {done, mem_req}); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_set_hl();
        int fw = 0;
        alu_result = 8'h08; alu_flags_out = 4'b1111;
        offer(1'b1, 8'hDE, 8'h00);
        mem_ack = 1'b1; mem_rdata = 8'h00; #1;
        total++; if ({mem_req, mem_we} !== 2'b10) $display("FAIL set_fetch got=%b want=10", {mem_req, mem_we}); else passed++;
        if (f_wr_en === 1'b1) fw++;
        @(posedge clk); #1; mem_ack = 1'b0;
        total++; if ({alu_op, alu_bit_index, alu_b} !== {5'b11111, 3'd3, 8'h00}) $display("FAIL set_alu got=%b/%0d/%h want=11111/3/00", alu_op, alu_bit_index, alu_b); else passed++;
        total++; if ({rf_wr_en, done} !== 2'b00) $display("FAIL set_exec_strobes got=%b want=00", {rf_wr_en, done}); else passed++;
        if (f_wr_en === 1'b1) fw++;
        @(posedge clk); #1;
        total++; if ({mem_req, mem_we, mem_wdata, done} !== {2'b11, 8'h08, 1'b0}) $display("FAIL set_wb got=%b%b/%h/%b want=11/08/0", mem_req, mem_we, mem_wdata, done); else passed++;
        if (f_wr_en === 1'b1) fw++;
        mem_ack = 1'b1; #1;
        total++; if ({done, err} !== 2'b10) $display("FAIL set_done_on_ack got=%b want=10", {done, err}); else passed++;
        @(posedge clk); #1; mem_ack = 1'b0;
        total++; if ({in_ready, mem_req, fw} !== {2'b10, 32'd0}) $display("FAIL set_end got=%b%b fw=%0d want=10 fw=0", in_ready, mem_req, fw); else passed++;
    endtask

    task automatic test_rlca();
        regs[7] = 8'h80; alu_result = 8'h01; alu_flags_out = 4'b0001;
        offer(1'b0, 8'h07, 8'h00);
        total++; if ({alu_op, alu_a, alu_b} !== {5'b01000, 8'h80, 8'h80}) $display("FAIL rlca_alu got=%b/%h/%h want=01000/80/80", alu_op, alu_a, alu_b); else passed++;
        total++; if ({rf_wr_sel, rf_wr_data, f_out} !== {3'd7, 8'h01, 4'b0001}) $display("FAIL rlca_wb got=%0d/%h/%b want=7/01/0001", rf_wr_sel, rf_wr_data, f_out); else passed++;
        @(posedge clk); #1;
        regs[7] = 8'h00; alu_result = 8'h00; alu_flags_out = 4'b1000;
        offer(1'b0, 8'h07, 8'h00);
        total++; if ({f_wr_en, f_out} !== 5'b10000) $display("FAIL rlca_zforce got=%b want=10000", {f_wr_en, f_out}); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_swap();
        regs[0] = 8'h00; alu_result = 8'h00; alu_flags_out = 4'b0000;
        offer(1'b1, 8'h30, 8'h00);
        total++; if ({alu_op, alu_a, rf_wr_sel} !== {5'b01110, 8'h00, 3'd0}) $display("FAIL swap0_alu got=%b/%h/%0d want=01110/00/0", alu_op, alu_a, rf_wr_sel); else passed++;
        total++; if ({rf_wr_en, f_out} !== 5'b11000) $display("FAIL swap0_flags got=%b want=11000", {rf_wr_en, f_out}); else passed++;
        @(posedge clk); #1;
        regs[0] = 8'h12; alu_result = 8'h21; alu_flags_out = 4'b1000;
        offer(1'b1, 8'h30, 8'h00);
        total++; if ({alu_a, rf_wr_data, f_out} !== {8'h12, 8'h21, 4'b0000}) $display("FAIL swap12 got=%h/%h/%b want=12/21/0000", alu_a, rf_wr_data, f_out); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_undef();
        offer(1'b0, 8'h00, 8'h00);
        total++; if ({done, err, rf_wr_en, f_wr_en, mem_req} !== 5'b11000) $display("FAIL undef got=%b want=11000", {done, err, rf_wr_en, f_wr_en, mem_req}); else passed++;
        total++; if (alu_op !== 5'b11000) $display("FAIL undef_alu_op got=%b want=11000", alu_op); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        int reqs = 0;
        offer(1'b0, 8'h86, 8'h00);
        for (int i = 0; i < 4; i++) begin
            if (mem_req === 1'b1 && done === 1'b0) reqs++;
            @(posedge clk); #1;
        end
        total++; if (reqs !== 4) $display("FAIL timeout_req_cycles got=%0d want=4", reqs); else passed++;
        total++; if ({mem_req, done, err, rf_wr_en, f_wr_en} !== 5'b01100) $display("FAIL timeout_abort got=%b want=01100", {mem_req, done, err, rf_wr_en, f_wr_en}); else passed++;
        @(posedge clk); #1;
        total++; if ({in_ready, done, f_wr_en} !== 3'b100) $display("FAIL timeout_idle got=%b want=100", {in_ready, done, f_wr_en}); else passed++;
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        offer(1'b0, 8'h86, 8'h00);
        @(posedge clk); #2;
        rst = 1'b1; #1;
        total++; if ({mem_req, in_ready, done} !== 3'b010) $display("FAIL midreset_async got=%b want=010", {mem_req, in_ready, done}); else passed++;
        @(posedge clk); #1; rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (done === 1'b1) dones++;
            @(posedge clk); #1;
        end
        total++; if ({dones, in_ready} !== {32'd0, 1'b1}) $display("FAIL midreset_no_done got dones=%0d ready=%b want 0/1", dones, in_ready); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) regs[i] = 8'h00;
        test_reset();
        test_add();
        test_imm();
        test_cp_hl();
        test_set_hl();
        test_rlca();
        test_swap();
        test_undef();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
